// File: rtl/ula_pkg.sv
// Shared types and constants for the multibyte ALU sequencer.
//   ula_seq_state_t : sequencer FSM states
//   ula_cmd_t       : command fields latched at command accept
//   S_*             : commonly used 74181 function-select codes
package ula_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} ula_seq_state_t;

  typedef struct packed {
    logic [3:0] s;
    logic       m;
  } ula_cmd_t;

  localparam logic [3:0] S_A_PLUS_B     = 4'b1001;
  localparam logic [3:0] S_A_MINUS_B_M1 = 4'b0110;
  localparam logic [3:0] S_LOG_XOR      = 4'b0110;

endpackage

// File: rtl/ula_8bits.sv
// 8-bit 74181-style ALU slice, purely combinational, active-high data.
//   a, b   : operand bytes
//   s, m   : function select, m=1 logic / m=0 arithmetic
//   c_in   : carry in, 1 = +1
//   f      : result byte
//   c_out  : carry out of bit 7 (arithmetic meaning only)
//   a_eq_b : high when f is all ones (the 74181 A=B output)
module ula_8bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [7:0] f,
  output logic       c_out,
  output logic       a_eq_b
);

  logic [7:0] x, y;
  logic [8:0] sum;

  // x/y are the two internal 74181 terms; arithmetic is x+y+cin, which
  // reproduces the full arithmetic table (e.g. 1001: (A|B)+(A&B) = A+B).
  // The logic table is the bitwise XNOR of the same two terms.
  always_comb begin
    x      = a | (b & {8{s[0]}}) | (~b & {8{s[1]}});
    y      = (a & ~b & {8{s[2]}}) | (a & b & {8{s[3]}});
    sum    = {1'b0, x} + {1'b0, y} + {8'd0, c_in};
    f      = m ? ~(x ^ y) : sum[7:0];
    c_out  = sum[8];
    a_eq_b = &f;
  end

endmodule

// File: rtl/ula_multibyte_seq.sv
// Sequential 8*NBYTES-bit ALU built on one ula_8bits slice, LSB byte first.
//   clk, rst_n                 : clock, async active-low reset
//   cmd_valid/ready, cmd_s/m/c_in : command channel (latched on handshake)
//   in_valid/ready, in_a/b     : operand byte-pair stream
//   out_valid/ready, out_f     : result byte stream (single output register)
//   out_last, out_c_out, out_eq : final-byte marker, final carry, aggregated equality
module ula_multibyte_seq
  import ula_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_s,
  input  logic       cmd_m,
  input  logic       cmd_c_in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_f,
  output logic       out_last,
  output logic       out_c_out,
  output logic       out_eq
);

  localparam int IDX_W = $clog2(NBYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  ula_seq_state_t state, state_nxt;
  ula_cmd_t       cmd_q;
  logic           carry, eq_acc;
  logic [IDX_W-1:0] idx;

  logic [7:0] f;
  logic       c_out, a_eq_b;
  logic       cmd_fire, in_fire, out_fire, is_last;

  ula_8bits u_alu (
    .a      (in_a),
    .b      (in_b),
    .s      (cmd_q.s),
    .m      (cmd_q.m),
    .c_in   (carry),
    .f      (f),
    .c_out  (c_out),
    .a_eq_b (a_eq_b)
  );

  assign out_fire = out_valid && out_ready;
  assign is_last  = (idx == LAST_IDX);

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && is_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (out_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_fire = cmd_valid && cmd_ready;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q     <= '0;
      carry     <= 1'b0;
      eq_acc    <= 1'b1;
      idx       <= '0;
      out_valid <= 1'b0;
      out_f     <= '0;
      out_last  <= 1'b0;
      out_c_out <= 1'b0;
      out_eq    <= 1'b0;
    end else begin
      if (cmd_fire) begin
        cmd_q  <= '{s: cmd_s, m: cmd_m};
        carry  <= cmd_c_in;
        eq_acc <= 1'b1;
        idx    <= '0;
      end
      if (in_fire) begin
        out_f     <= f;
        out_valid <= 1'b1;
        // Logic ops never propagate a carry between bytes.
        carry     <= cmd_q.m ? carry : c_out;
        eq_acc    <= eq_acc & a_eq_b;
        idx       <= idx + 1'b1;
        if (is_last) begin
          out_last  <= 1'b1;
          out_c_out <= c_out & ~cmd_q.m;
          out_eq    <= eq_acc & a_eq_b;
        end
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_c_out <= 1'b0;
        out_eq    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ula_multibyte_seq.sv
module tb_ula_multibyte_seq;
  import ula_pkg::*;

  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [3:0] cmd_s = '0;
  logic       cmd_m = 1'b0, cmd_c_in = 1'b0;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] in_a = '0, in_b = '0;
  logic       out_valid, out_ready = 1'b1;
  logic [7:0] out_f;
  logic       out_last, out_c_out, out_eq;

  int checks = 0;
  int passed = 0;

  ula_multibyte_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_s(cmd_s), .cmd_m(cmd_m), .cmd_c_in(cmd_c_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
    .out_last(out_last), .out_c_out(out_c_out), .out_eq(out_eq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Offer a command at a negedge; a junk byte pair is offered too and
  // must not be consumed while idle.
  task automatic send_cmd(input logic [3:0] s, input logic m, input logic cin);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_s = s; cmd_m = m; cmd_c_in = cin;
    in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h3C;
    #1;
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_in_ready", in_ready, 0);
    @(negedge clk);
    cmd_valid = 1'b0; in_valid = 1'b0;
    chk("load_cmd_ready", cmd_ready, 0);
  endtask

  task automatic stream(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic exp_c, input logic exp_eq,
                        input int stall);
    for (int i = 0; i <= NB; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_f"}, out_f, exp[8*(i-1) +: 8]);
        chk({tag, "_last"}, out_last, (i == NB));
        if (i == NB) begin
          chk({tag, "_c_out"}, out_c_out, exp_c);
          chk({tag, "_eq"}, out_eq, exp_eq);
        end
        if (i == 1 && stall > 0) begin
          out_ready = 1'b0;
          in_valid = 1'b1; in_a = a[15:8]; in_b = b[15:8];
          repeat (stall) begin
            @(negedge clk);
            chk({tag, "_bp_in_ready"}, in_ready, 0);
            chk({tag, "_bp_valid"}, out_valid, 1);
            chk({tag, "_bp_f"}, out_f, exp[7:0]);
          end
          out_ready = 1'b1;
        end
      end
      if (i < NB) begin
        in_valid = 1'b1; in_a = a[8*i +: 8]; in_b = b[8*i +: 8];
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk({tag, "_done_valid"}, out_valid, 0);
    chk({tag, "_done_cmd_ready"}, cmd_ready, 1);
  endtask

  initial begin
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_f", out_f, 0);
    chk("rst_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;

    send_cmd(S_A_PLUS_B, 1'b0, 1'b0);
    stream("add1", 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 0);

    send_cmd(S_A_PLUS_B, 1'b0, 1'b1);
    stream("add2", 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 0);

    send_cmd(S_A_MINUS_B_M1, 1'b0, 1'b0);
    stream("sub_eq", 32'h12345678, 32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b1, 0);

    send_cmd(S_A_MINUS_B_M1, 1'b0, 1'b0);
    stream("sub_ne", 32'h12345678, 32'h12345679, 32'hFFFFFFFE, 1'b0, 1'b0, 0);

    send_cmd(S_LOG_XOR, 1'b1, 1'b1);
    stream("xor", 32'h5A5A5A5A, 32'h33333333, 32'h69696969, 1'b0, 1'b0, 0);

    // Backpressure for 3 cycles after the first result.
    send_cmd(S_A_PLUS_B, 1'b0, 1'b0);
    stream("bp", 32'h11223344, 32'h01010101, 32'h12233445, 1'b0, 1'b0, 3);

    // Reset mid-operation while the carry chain holds a 1.
    send_cmd(S_A_PLUS_B, 1'b0, 1'b1);
    @(negedge clk); in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h00;
    @(negedge clk); in_a = 8'hFF; in_b = 8'h00;
    @(negedge clk); in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;

    send_cmd(S_A_PLUS_B, 1'b0, 1'b0);
    stream("post_rst", 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
